// File: rtl/regbank_ctrl.sv
// Command-driven controller for a register bank on a shared 16-bit tristate data bus.
// It runs WRITE, READ and MOVE bank cycles and returns one registered response per command.
module regbank_ctrl #(
  parameter int unsigned RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_dst,
  input  logic [2:0]  cmd_src,
  input  logic        cmd_size,
  input  logic        cmd_hl_dst,
  input  logic        cmd_hl_src,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  select_reg,
  output logic        size,
  output logic        select_high_low,
  output logic        select_data_h_reg,
  output logic        read_write,
  inout  wire  [15:0] data
);

  typedef enum logic [2:0] {
    StIdle, StWr, StRdWait, StRd, StMvRd, StMvWr, StResp
  } state_e;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpMove  = 2'b10;
  localparam logic [2:0] WaitLast = 3'(RD_WAIT > 0 ? RD_WAIT - 1 : 0);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  dst_q, dst_d, src_q, src_d;
  logic        sz_q, sz_d, hld_q, hld_d, hls_q, hls_d;
  logic [15:0] res_q, res_d, wdat_q, wdat_d;
  logic        err_q, err_d;
  logic        rw_q, rw_d, size_q, size_d, hl_q, hl_d;
  logic [2:0]  sel_q, sel_d;
  logic        cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        accept;
  logic [15:0] rd_val;

  // Bank always returns a full word; byte reads pick one half and zero-extend.
  assign rd_val = sz_q ? data : {8'h00, (hls_q ? data[15:8] : data[7:0])};
  assign accept = cmd_valid && cmd_ready_q;

  always_comb begin
    op_d   = accept ? cmd_op     : op_q;
    dst_d  = accept ? cmd_dst    : dst_q;
    src_d  = accept ? cmd_src    : src_q;
    sz_d   = accept ? cmd_size   : sz_q;
    hld_d  = accept ? cmd_hl_dst : hld_q;
    hls_d  = accept ? cmd_hl_src : hls_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    wdat_d  = wdat_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = 3'd0;
          res_d = 16'h0000;
          err_d = 1'b0;
          case (cmd_op)
            OpWrite: begin
              state_d = StWr;
              wdat_d  = cmd_size ? cmd_wdata : {8'h00, cmd_wdata[7:0]};
            end
            OpRead:  state_d = (RD_WAIT == 0) ? StRd : StRdWait;
            OpMove:  state_d = (RD_WAIT == 0) ? StMvRd : StRdWait;
            default: begin
              state_d = StResp;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      StWr: state_d = StResp;
      StRdWait: begin
        if (cnt_q == WaitLast) begin
          state_d = (op_q == OpMove) ? StMvRd : StRd;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRd: begin
        res_d   = rd_val;
        state_d = StResp;
      end
      StMvRd: begin
        wdat_d  = rd_val;
        state_d = StMvWr;
      end
      StMvWr: state_d = StResp;
      StResp: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bank controls track the state being entered; the response trails the state by one cycle.
  always_comb begin
    rw_d   = 1'b0;
    sel_d  = 3'd0;
    size_d = 1'b1;
    hl_d   = 1'b0;
    case (state_d)
      StWr, StMvWr: begin
        rw_d   = 1'b1;
        sel_d  = dst_d;
        size_d = sz_d;
        hl_d   = hld_d;
      end
      StRdWait, StRd, StMvRd: sel_d = src_d;
      default: ;
    endcase
    cmd_ready_d = (state_d == StIdle);
    rsp_valid_d = (state_q == StResp) && !(rsp_valid_q && rsp_ready);
    rsp_data_d  = rsp_valid_d ? res_q : 16'h0000;
    rsp_err_d   = rsp_valid_d ? err_q : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      op_q        <= 2'b00;
      dst_q       <= 3'd0;
      src_q       <= 3'd0;
      sz_q        <= 1'b1;
      hld_q       <= 1'b0;
      hls_q       <= 1'b0;
      res_q       <= 16'h0000;
      err_q       <= 1'b0;
      wdat_q      <= 16'h0000;
      rw_q        <= 1'b0;
      sel_q       <= 3'd0;
      size_q      <= 1'b1;
      hl_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      sz_q        <= sz_d;
      hld_q       <= hld_d;
      hls_q       <= hls_d;
      res_q       <= res_d;
      err_q       <= err_d;
      wdat_q      <= wdat_d;
      rw_q        <= rw_d;
      sel_q       <= sel_d;
      size_q      <= size_d;
      hl_q        <= hl_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign data              = rw_q ? wdat_q : 16'hzzzz;
  assign cmd_ready         = cmd_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_data          = rsp_data_q;
  assign rsp_err           = rsp_err_q;
  assign select_reg        = sel_q;
  assign size              = size_q;
  assign select_high_low   = hl_q;
  assign select_data_h_reg = 1'b0;
  assign read_write        = rw_q;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed bench for regbank_ctrl: two instances (RD_WAIT 0 and 3), each with a behavioural
// register bank on its data bus, and a response scoreboard fed from a reference register file.
module tb_regbank_ctrl;

  logic        clk, reset;
  logic        cmd_valid, cmd_valid3, rsp_ready, rsp_ready3;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_dst, cmd_src;
  logic        cmd_size, cmd_hl_dst, cmd_hl_src;
  logic [15:0] cmd_wdata;

  logic        cmd_ready, rsp_valid, rsp_err, size, hl, dh, rw;
  logic [15:0] rsp_data;
  logic [2:0]  sel;
  wire  [15:0] data;
  logic        cmd_ready3, rsp_valid3, rsp_err3, size3, hl3, dh3, rw3;
  logic [15:0] rsp_data3;
  logic [2:0]  sel3;
  wire  [15:0] data3;

  logic [15:0] bank0 [8];
  logic [15:0] bank3 [8];
  logic [15:0] ref0 [8];
  logic [15:0] ref3 [8];
  logic [15:0] sb_data [$];
  logic        sb_err [$];
  int          checks = 0;
  int          failures = 0;

  regbank_ctrl #(.RD_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_size(cmd_size), .cmd_hl_dst(cmd_hl_dst),
    .cmd_hl_src(cmd_hl_src), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .select_reg(sel),
    .size(size), .select_high_low(hl), .select_data_h_reg(dh), .read_write(rw), .data(data)
  );

  regbank_ctrl #(.RD_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_size(cmd_size), .cmd_hl_dst(cmd_hl_dst),
    .cmd_hl_src(cmd_hl_src), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3), .select_reg(sel3),
    .size(size3), .select_high_low(hl3), .select_data_h_reg(dh3), .read_write(rw3),
    .data(data3)
  );

  // Bank models: drive the addressed word while reading, latch the bus on write edges.
  assign data  = rw  ? 16'hzzzz : bank0[sel];
  assign data3 = rw3 ? 16'hzzzz : bank3[sel3];

  always @(posedge clk) begin
    if (rw) begin
      if (size)    bank0[sel]       <= data;
      else if (hl) bank0[sel][15:8] <= data[7:0];
      else         bank0[sel][7:0]  <= data[7:0];
    end
    if (rw3) begin
      if (size3)    bank3[sel3]       <= data3;
      else if (hl3) bank3[sel3][15:8] <= data3[7:0];
      else          bank3[sel3][7:0]  <= data3[7:0];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_rv(input bit u3);  return u3 ? rsp_valid3 : rsp_valid;  endfunction
  function automatic logic o_rw(input bit u3);  return u3 ? rw3 : rw;                endfunction
  function automatic logic o_cr(input bit u3);  return u3 ? cmd_ready3 : cmd_ready;  endfunction
  function automatic logic o_re(input bit u3);  return u3 ? rsp_err3 : rsp_err;      endfunction
  function automatic logic [15:0] o_rd(input bit u3);  return u3 ? rsp_data3 : rsp_data; endfunction
  function automatic logic [15:0] o_bus(input bit u3); return u3 ? data3 : data;         endfunction

  // Issue one command, check latency, bank write activity and the response, then complete it.
  task automatic do_cmd(input bit u3, input logic [1:0] op, input logic [2:0] dst,
                        input logic [2:0] src, input logic sz, input logic hld,
                        input logic hls, input logic [15:0] wd, input int hold,
                        input bit poke, input string tag);
    logic [15:0] v, wv, ed, old, nw, bus_seen, exp_d;
    logic        ee, exp_e;
    int          el, exp_rw, rw_n, lat, w;
    w  = u3 ? 3 : 0;
    v  = u3 ? ref3[src] : ref0[src];
    v  = sz ? v : {8'h00, (hls ? v[15:8] : v[7:0])};
    ed = 16'h0000; ee = 1'b0; exp_rw = 0; wv = 16'h0000; el = 1;
    case (op)
      2'b00:   begin wv = sz ? wd : {8'h00, wd[7:0]}; exp_rw = 1; el = 2; end
      2'b01:   begin ed = v; el = 2 + w; end
      2'b10:   begin wv = v; exp_rw = 1; el = 3 + w; end
      default: begin ee = 1'b1; el = 1; end
    endcase
    if (exp_rw == 1) begin
      old = u3 ? ref3[dst] : ref0[dst];
      nw  = sz ? wv : (hld ? {wv[7:0], old[7:0]} : {old[15:8], wv[7:0]});
      if (u3) ref3[dst] = nw;
      else    ref0[dst] = nw;
    end
    sb_data.push_back(ed);
    sb_err.push_back(ee);

    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_size = sz;
    cmd_hl_dst = hld; cmd_hl_src = hls; cmd_wdata = wd;
    for (int i = 0; i < 20 && !o_cr(u3); i++) begin
      @(posedge clk); #1;
    end
    if (!o_cr(u3)) begin
      check({tag, " ready_timeout"}, 16'(o_cr(u3)), 16'h1);
      void'(sb_data.pop_front());
      void'(sb_err.pop_front());
      return;
    end
    if (u3) cmd_valid3 = 1'b1;
    else    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_valid3 = 1'b0;

    rw_n = 0; lat = -1; bus_seen = 16'h0000;
    for (int i = 0; i <= 20; i++) begin
      if (o_rv(u3)) begin lat = i; break; end
      if (o_rw(u3)) begin rw_n++; bus_seen = o_bus(u3); end
      @(posedge clk); #1;
    end
    exp_d = sb_data.pop_front();
    exp_e = sb_err.pop_front();
    check({tag, " latency"}, 16'(lat), 16'(el));
    check({tag, " rw_cycles"}, 16'(rw_n), 16'(exp_rw));
    if (exp_rw == 1) check({tag, " wr_bus"}, bus_seen, wv);
    if (lat < 0) return;
    check({tag, " rsp_data"}, o_rd(u3), exp_d);
    check({tag, " rsp_err"}, 16'(o_re(u3)), 16'(exp_e));

    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        cmd_op = 2'b00; cmd_dst = 3'd0; cmd_size = 1'b1; cmd_wdata = 16'hDEAD;
        cmd_valid = 1'b1;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check({tag, " hold_valid"}, 16'(o_rv(u3)), 16'h1);
      check({tag, " hold_data"}, o_rd(u3), exp_d);
      check({tag, " hold_ready"}, 16'(o_cr(u3)), 16'h0);
      check({tag, " hold_rw"}, 16'(o_rw(u3)), 16'h0);
    end

    if (u3) rsp_ready3 = 1'b1;
    else    rsp_ready  = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    check({tag, " done_valid"}, 16'(o_rv(u3)), 16'h0);
    check({tag, " done_ready"}, 16'(o_cr(u3)), 16'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cmd_ready"}, 16'(cmd_ready), 16'h0);
    check({tag, " rsp_valid"}, 16'(rsp_valid), 16'h0);
    check({tag, " rsp_data"}, rsp_data, 16'h0000);
    check({tag, " rsp_err"}, 16'(rsp_err), 16'h0);
    check({tag, " select_reg"}, 16'(sel), 16'h0);
    check({tag, " size"}, 16'(size), 16'h1);
    check({tag, " hl"}, 16'(hl), 16'h0);
    check({tag, " data_h"}, 16'(dh), 16'h0);
    check({tag, " read_write"}, 16'(rw), 16'h0);
    check({tag, " rw3"}, 16'(rw3), 16'h0);
    check({tag, " data_h3"}, 16'(dh3), 16'h0);
    check({tag, " ready3"}, 16'(cmd_ready3), 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ref0[i] = 16'h0000;
      ref3[i] = 16'h0000;
    end
    reset = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    cmd_op = 2'b00; cmd_dst = 3'd0; cmd_src = 3'd0; cmd_size = 1'b1;
    cmd_hl_dst = 1'b0; cmd_hl_src = 1'b0; cmd_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset cmd_ready", 16'(cmd_ready), 16'h1);

    // Word write then read of AX.
    do_cmd(0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'hABCD, 0, 0, "wr_ax");
    do_cmd(0, 2'b01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "rd_ax");
    // Byte writes to BL/BH, word and byte reads.
    do_cmd(0, 2'b00, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h77EF, 0, 0, "wr_bl");
    do_cmd(0, 2'b00, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 16'h5512, 0, 0, "wr_bh");
    do_cmd(0, 2'b01, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "rd_bx");
    do_cmd(0, 2'b01, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 0, "rd_bh");
    do_cmd(0, 2'b01, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, "rd_bl");
    // Moves: byte CL->DH, word CX->SI, and BX onto itself.
    do_cmd(0, 2'b00, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 16'h3456, 0, 0, "wr_cx");
    do_cmd(0, 2'b00, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 16'h789A, 0, 0, "wr_dx");
    do_cmd(0, 2'b10, 3'd3, 3'd2, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0, "mv_cl_dh");
    do_cmd(0, 2'b01, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "rd_dx");
    check("ref dx", ref0[3], 16'h569A);
    do_cmd(0, 2'b10, 3'd6, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "mv_cx_si");
    do_cmd(0, 2'b01, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "rd_si");
    do_cmd(0, 2'b10, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "mv_bx_bx");
    do_cmd(0, 2'b01, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "rd_bx2");
    // Back-pressure with an ignored command pulse, then prove AX was untouched.
    do_cmd(0, 2'b01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 4, 1, "rd_ax_hold");
    do_cmd(0, 2'b01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "rd_ax_again");
    // Reserved opcode.
    do_cmd(0, 2'b11, 3'd5, 3'd4, 1'b1, 1'b0, 1'b0, 16'h1111, 2, 0, "reserved");
    // RD_WAIT=3 instance.
    do_cmd(1, 2'b00, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, 16'hFFFC, 0, 0, "w3_wr_sp");
    do_cmd(1, 2'b01, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 0, "w3_rd_sp");
    do_cmd(1, 2'b01, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, "w3_rd_spl");
    do_cmd(1, 2'b10, 3'd5, 3'd4, 1'b0, 1'b1, 1'b1, 16'h0000, 0, 0, "w3_mv_sph_bph");
    do_cmd(1, 2'b01, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "w3_rd_bp");

    // Reset while in MV_RD: move DX->CX must never write CX.
    cmd_op = 2'b10; cmd_dst = 3'd2; cmd_src = 3'd3; cmd_size = 1'b1;
    cmd_hl_dst = 1'b0; cmd_hl_src = 1'b0;
    check("rst_mv ready", 16'(cmd_ready), 16'h1);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("rst_mv mvrd_sel", 16'(sel), 16'h3);
    check("rst_mv mvrd_rw", 16'(rw), 16'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_mv");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_mv after_rw", 16'(rw), 16'h0);
      check("rst_mv after_valid", 16'(rsp_valid), 16'h0);
    end
    check("rst_mv cmd_ready", 16'(cmd_ready), 16'h1);
    check("rst_mv cx_kept", bank0[2], ref0[2]);
    do_cmd(0, 2'b01, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, "rd_cx_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
